// File: rtl/ifc_reduce.sv
// ----------------------------------------------------------------------------
// ifc_reduce
//   Merges NCH independent en/rdy input channels into one result channel.
//   Each channel is buffered in its own DEPTH-entry FIFO so producers may run
//   skewed; a result is formed only when every FIFO holds at least one word.
//   The heads of all FIFOs are popped together and reduced by OR / AND / XOR
//   or modulo-2^WIDTH ADD into a single registered output word.
//
// Parameters
//   WIDTH  data width per channel and of the result
//   NCH    number of input channels (2..16)
//   DEPTH  per-channel FIFO depth (power of two, >= 2)
//
// Ports
//   CLK      clock, all state updates on the rising edge
//   RST_N    synchronous active-low reset
//   mode     reduction select: 0 OR, 1 AND, 2 XOR, 3 ADD (sampled on fire)
//   in_data  channel i at bits [i*WIDTH +: WIDTH]
//   in_en    per-channel enqueue strobe (ignored while in_rdy[i] = 0)
//   in_rdy   per-channel FIFO not full (registered state only)
//   y_en     result dequeue strobe (ignored while y_rdy = 0)
//   y_data   current result word
//   y_rdy    result register holds a valid word
// ----------------------------------------------------------------------------
module ifc_reduce #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [1:0]             mode,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_en,
  output logic [NCH-1:0]         in_rdy,
  input  logic                   y_en,
  output logic [WIDTH-1:0]       y_data,
  output logic                   y_rdy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_ADD = 2'd3
  } mode_e;

  logic [WIDTH-1:0] mem [NCH][DEPTH];
  ptr_t             wr_ptr [NCH];
  ptr_t             rd_ptr [NCH];
  cnt_t             count  [NCH];

  logic [NCH-1:0]   push;
  logic [NCH-1:0]   nonempty;
  logic             fire;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] result;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // Handshake decode. in_rdy depends only on registered counts, so there is
  // no combinational path from y_en or in_en to in_rdy. A full channel that
  // also pops this cycle still refuses the push.
  // NOTE: every signal driven from always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_rdy   = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < NCH; i++) begin
      in_rdy[i]   = (count[i] != cnt_t'(DEPTH));
      nonempty[i] = (count[i] != '0);
      push[i]     = in_en[i] && in_rdy[i];
    end
  end

  // A result forms only when every channel has a head word and the output
  // register is either empty or being drained this cycle.
  assign fire = (&nonempty) && (!y_rdy || y_en);

  // Reduction across the current FIFO heads; ADD wraps modulo 2^WIDTH.
  always_comb begin
    result = (mode_sel == MODE_AND) ? '1 : '0;
    head   = '0;
    for (int i = 0; i < NCH; i++) begin
      head = mem[i][rd_ptr[i]];
      unique case (mode_sel)
        MODE_OR:  result = result | head;
        MODE_AND: result = result & head;
        MODE_XOR: result = result ^ head;
        MODE_ADD: result = result + head;
      endcase
    end
  end

  // Pointers, counts and the output register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      y_rdy  <= 1'b0;
      y_data <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + ptr_t'(1);
        end
        if (fire) begin
          rd_ptr[i] <= rd_ptr[i] + ptr_t'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        unique case ({push[i], fire})
          2'b10:   count[i] <= count[i] + cnt_t'(1);
          2'b01:   count[i] <= count[i] - cnt_t'(1);
          default: count[i] <= count[i];
        endcase
      end

      if (fire) begin
        y_data <= result;
        y_rdy  <= 1'b1;
      end else if (y_en) begin
        // Consumed with nothing to replace it: data holds, valid drops.
        y_rdy <= 1'b0;
      end
    end
  end

  // FIFO storage.
  // NOTE: the data array is deliberately not reset; occupancy counts alone
  // decide which entries are meaningful, so clearing storage buys nothing.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ifc_reduce.sv
// ----------------------------------------------------------------------------
// tb_ifc_reduce
//   Self-checking bench for ifc_reduce (WIDTH=8, NCH=4, DEPTH=2). A queue-based
//   reference model tracks per-channel contents and the result register; it
//   is compared against the DUT after every cycle. Table vectors and directed
//   sequences also check against fixed expected constants.
// ----------------------------------------------------------------------------
module tb_ifc_reduce;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 2;

  logic                 CLK;
  logic                 RST_N;
  logic [1:0]           mode;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_en;
  logic [NCH-1:0]       in_rdy;
  logic                 y_en;
  logic [WIDTH-1:0]     y_data;
  logic                 y_rdy;

  ifc_reduce #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .mode    (mode),
    .in_data (in_data),
    .in_en   (in_en),
    .in_rdy  (in_rdy),
    .y_en    (y_en),
    .y_data  (y_data),
    .y_rdy   (y_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [WIDTH-1:0] q [NCH][$];
  logic             m_yv;
  logic [WIDTH-1:0] m_yd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] reduce_ref(input int m, input logic [WIDTH-1:0] h [NCH]);
    int acc;
    case (m)
      0: begin acc = 0;   for (int i = 0; i < NCH; i++) acc = acc | int'(h[i]); end
      1: begin acc = 255; for (int i = 0; i < NCH; i++) acc = acc & int'(h[i]); end
      2: begin acc = 0;   for (int i = 0; i < NCH; i++) acc = acc ^ int'(h[i]); end
      default: begin
        acc = 0;
        for (int i = 0; i < NCH; i++) acc = acc + int'(h[i]);
        acc = acc % 256;
      end
    endcase
    return acc[WIDTH-1:0];
  endfunction

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input logic rst_n, input logic [NCH-1:0] en,
                            input logic [NCH*WIDTH-1:0] d, input logic [1:0] m,
                            input logic yen);
    logic             all_ne;
    logic             do_fire;
    logic [NCH-1:0]   acc_push;
    logic [WIDTH-1:0] heads [NCH];
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
      m_yv = 1'b0;
      m_yd = '0;
      return;
    end
    all_ne = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (q[i].size() == 0) all_ne = 1'b0;
      acc_push[i] = en[i] && (q[i].size() < DEPTH);
    end
    do_fire = all_ne && (!m_yv || yen);
    if (do_fire) begin
      for (int i = 0; i < NCH; i++) heads[i] = q[i].pop_front();
      m_yd = reduce_ref(int'(m), heads);
      m_yv = 1'b1;
    end else if (yen) begin
      m_yv = 1'b0;
    end
    for (int i = 0; i < NCH; i++)
      if (acc_push[i]) q[i].push_back(d[i*WIDTH +: WIDTH]);
  endtask

  function automatic logic [NCH-1:0] model_rdy();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (q[i].size() < DEPTH);
    return r;
  endfunction

  // Drive one cycle, update the model at the edge, compare at the falling edge.
  task automatic cycle(input logic rst_n, input logic [NCH-1:0] en,
                       input logic [NCH*WIDTH-1:0] d, input logic [1:0] m,
                       input logic yen);
    RST_N   = rst_n;
    in_en   = en;
    in_data = d;
    mode    = m;
    y_en    = yen;
    @(posedge CLK);
    model_step(rst_n, en, d, m, yen);
    @(negedge CLK);
    check("model_in_rdy", 32'(in_rdy), 32'(model_rdy()));
    check("model_y_rdy",  32'(y_rdy),  32'(m_yv));
    check("model_y_data", 32'(y_data), 32'(m_yd));
  endtask

  typedef struct {
    logic [1:0]           m;
    logic [NCH*WIDTH-1:0] d;  // {ch3, ch2, ch1, ch0}
    logic [WIDTH-1:0]     exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'd0, 32'h80_04_02_01, 8'h87};
    vecs[1] = '{2'd1, 32'hF0_F0_F0_F0, 8'hF0};
    vecs[2] = '{2'd2, 32'h00_00_0F_FF, 8'hF0};
    vecs[3] = '{2'd3, 32'h00_01_02_FF, 8'h02};
    vecs[4] = '{2'd0, 32'h00_00_00_00, 8'h00};
    vecs[5] = '{2'd3, 32'h80_80_80_80, 8'h00};
    vecs[6] = '{2'd1, 32'hFF_7F_FE_FF, 8'h7E};
    vecs[7] = '{2'd2, 32'h88_44_22_11, 8'hFF};

    RST_N = 1'b0; in_en = '0; in_data = '0; mode = '0; y_en = 1'b0;
    m_yv = 1'b0; m_yd = '0;

    // Reset with stray strobes that must be ignored.
    cycle(1'b0, 4'hF, 32'hDEAD_BEEF, 2'd0, 1'b1);
    cycle(1'b0, '0, '0, 2'd0, 1'b0);
    check("rst_in_rdy", 32'(in_rdy), 32'hF);
    check("rst_y_rdy",  32'(y_rdy),  32'h0);
    check("rst_y_data", 32'(y_data), 32'h00);
    cycle(1'b1, '0, '0, 2'd0, 1'b1);
    check("idle_yen_y_rdy",  32'(y_rdy),  32'h0);
    check("idle_yen_in_rdy", 32'(in_rdy), 32'hF);

    // Table: one word per channel, result two edges after enqueue.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 4'hF, vecs[k].d, vecs[k].m, 1'b0);
      check("tbl_not_yet", 32'(y_rdy), 32'h0);
      cycle(1'b1, '0, '0, vecs[k].m, 1'b0);
      check("tbl_y_rdy",  32'(y_rdy),  32'h1);
      check("tbl_y_data", 32'(y_data), 32'(vecs[k].exp));
      cycle(1'b1, '0, '0, vecs[k].m, 1'b1);
      check("tbl_drained", 32'(y_rdy), 32'h0);
    end

    // Skew: channel 0 runs ahead; its third word is dropped when full.
    cycle(1'b1, 4'b0001, 32'h00_00_00_10, 2'd3, 1'b1);
    cycle(1'b1, 4'b0001, 32'h00_00_00_20, 2'd3, 1'b1);
    check("skew_ch0_full", 32'(in_rdy), 32'hE);
    cycle(1'b1, 4'b0001, 32'h00_00_00_30, 2'd3, 1'b1);
    cycle(1'b1, 4'b1110, 32'h03_02_01_00, 2'd3, 1'b1);
    check("skew_wait", 32'(y_rdy), 32'h0);
    cycle(1'b1, '0, '0, 2'd3, 1'b1);
    check("skew_res1", 32'(y_data), 32'h16);
    check("skew_res1_v", 32'(y_rdy), 32'h1);
    cycle(1'b1, 4'b1110, 32'h06_05_04_00, 2'd3, 1'b1);
    cycle(1'b1, '0, '0, 2'd3, 1'b1);
    check("skew_res2", 32'(y_data), 32'h2F);
    cycle(1'b1, '0, '0, 2'd3, 1'b1);
    check("skew_lost_word", 32'(y_rdy), 32'h0);
    check("skew_empty", 32'(in_rdy), 32'hF);

    // Backpressure: fill everything with y_en low, then drain continuously.
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 4'hF, {4{8'(k + 1)}} ^ 32'h0102_0408, 2'd2, 1'b0);
    check("bp_full", 32'(in_rdy), 32'h0);
    check("bp_held", 32'(y_rdy), 32'h1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'hF, 32'hAAAA_AAAA, 2'd2, 1'b0);
    check("bp_stable", 32'(y_data), 32'h0F);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, '0, '0, 2'd2, 1'b1);
      check("bp_stream", 32'(y_rdy), 32'(k < 2));
    end

    // Reset mid-stream with a pending result and partly full FIFOs.
    cycle(1'b1, 4'hF, 32'h11_11_11_11, 2'd0, 1'b0);
    cycle(1'b1, 4'hF, 32'h22_22_22_22, 2'd0, 1'b0);
    cycle(1'b0, 4'hF, 32'h44_44_44_44, 2'd0, 1'b1);
    check("mid_rst_y_rdy",  32'(y_rdy),  32'h0);
    check("mid_rst_in_rdy", 32'(in_rdy), 32'hF);
    cycle(1'b1, 4'hF, 32'h08_04_02_01, 2'd0, 1'b0);
    cycle(1'b1, '0, '0, 2'd0, 1'b0);
    check("mid_rst_fresh", 32'(y_data), 32'h0F);

    // Mode switch while a result is held.
    cycle(1'b1, '0, '0, 2'd0, 1'b1);
    cycle(1'b1, 4'hF, 32'h08_04_02_01, 2'd0, 1'b0);
    cycle(1'b1, '0, '0, 2'd0, 1'b0);
    cycle(1'b1, 4'hF, 32'h01_01_01_01, 2'd3, 1'b0);
    check("mode_hold", 32'(y_data), 32'h0F);
    cycle(1'b1, '0, '0, 2'd3, 1'b1);
    check("mode_add", 32'(y_data), 32'h04);
    cycle(1'b1, '0, '0, 2'd3, 1'b1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      cycle(($urandom_range(63) != 0), 4'($urandom), $urandom, 2'($urandom),
            ($urandom_range(3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifc_reduce.md
# ifc_reduce

Parametrised successor to the two-input OR combiner: merges NCH independent enable/ready input channels of WIDTH bits into one output channel through a selectable bitwise or arithmetic reduction. Each input has its own DEPTH-entry FIFO, so producers run skewed; a result forms only when every channel holds a word. It sits between independent producer interfaces and a single consumer in the same method-style (en/rdy) handshake fabric.

## Interface
- WIDTH, 8, data width per channel and of the result
- NCH, 4, number of input channels (2..16)
- DEPTH, 2, per-channel input FIFO depth (power of two, ≥2)
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  reset; one clock; reset is synchronous and active-low
- mode  input  2  reduction select: 0 OR, 1 AND, 2 XOR, 3 ADD
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_en  input  NCH  enqueue strobe per channel
- in_rdy  output  NCH  channel i FIFO not full
- y_en  input  1  dequeue strobe for the result
- y_data  output  WIDTH  current result word
- y_rdy  output  1  result register holds a valid word

## Operation
- Per channel: FIFO of DEPTH × WIDTH with wrap-around read/write pointers plus occupancy count (0..DEPTH).
- in_rdy[i] = (count_i != DEPTH), from registered state only; no combinational path from y_en or in_en.
- in_en[i] while in_rdy[i]=0 is ignored: no write, no pointer/count change, data dropped.
- Output stage: one register y_data plus valid flag y_rdy.
- fire = (all count_i != 0) && (!y_rdy || y_en).
- On fire: pop head of every channel simultaneously; y_data ← reduce(heads, mode); y_rdy ← 1.
- y_en with y_rdy=1 and no fire: y_rdy ← 0; y_data holds its last value.
- y_en while y_rdy=0 is ignored.
- Reduction: OR/AND/XOR bitwise across all NCH heads; ADD = sum of all heads modulo 2^WIDTH (carry discarded, no saturation).
- mode is sampled in the fire cycle only; changing mode never alters an already-registered y_data.
- Same-cycle push and pop on a channel (count between 1 and DEPTH−1): count unchanged, both pointers advance.
- Push on a full channel is impossible (in_rdy=0) even if that channel pops the same cycle; pop on an empty channel never occurs because fire requires all non-empty.

## Timing
- Reset (RST_N=0 at an edge): all counts and pointers 0, in_rdy = all ones, y_rdy=0, y_data=0. FIFO storage need not be cleared. Reset mid-operation discards all queued words and any pending result; in_en/y_en during reset cycles are ignored.
- Latency: word written at edge t on the last-completing channel → fire in cycle t..t+1 → y_rdy=1 after edge t+1 (two edges from in_en to y_rdy).
- Throughput: one result per cycle when all channels stay non-empty and y_en is held high.
- in_rdy[i] deasserts the cycle after the write that filled the FIFO and reasserts the cycle after the pop that freed a slot.
- y_rdy held with y_en=0 keeps y_data stable indefinitely (backpressure); input FIFOs then fill to DEPTH and in_rdy drops.

## Test plan
- Reset: after two cycles RST_N=0 → in_rdy=4'b1111, y_rdy=0, y_data=8'h00; pulse y_en → no change.
- Single word, all modes: channels 0..3 = 8'h01,8'h02,8'h04,8'h80 enqueued same cycle → y_rdy two edges later with OR=8'h87; repeat AND with all 8'hF0 → 8'hF0; XOR 8'hFF,8'h0F,8'h00,8'h00 → 8'hF0; ADD 8'hFF,8'h02,8'h01,8'h00 → 8'h02 (wrap).
- Skew: channel 0 gets 3 words early, others one at a time later → results issue in order only once each channel supplies its matching word; channel 0 in_rdy low after 2 words, third in_en ignored (word lost).
- Backpressure: y_en=0 with 2 results queued → y_data stable, all in_rdy=0 after FIFOs fill; release y_en=1 continuously → one result per cycle, then y_rdy=0.
- Reset mid-stream: RST_N=0 with y_rdy=1 and FIFOs partially full → next cycle y_rdy=0, in_rdy all ones; fresh words produce correct result with no stale data mixed in.
- Mode switch: change mode from OR to ADD while y_rdy=1, y_en=0 → y_data unchanged; the next result uses ADD.
